// File: rtl/pwm_reg_pkg.sv
// Shared constants, FSM encodings and write payload for the PWM register controller.
// Build option: define PWM_SHADOW_EN for double-buffered (shadow/active) registers.
package pwm_reg_pkg;

    localparam int unsigned ADDR_W       = 4;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned NREG_DEFAULT = 8;

    localparam logic [ADDR_W-1:0] CTRL_ADDR    = 4'hF;
    localparam int unsigned       CTRL_UPD_BIT = 0;

    // Update sequencer: wait for arm, wait for period boundary, copy for one cycle.
    typedef enum logic [1:0] {
        UPD_IDLE  = 2'd0,
        UPD_ARMED = 2'd1,
        UPD_COPY  = 2'd2
    } upd_state_t;

    // Single bank write after arbitration.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } reg_wr_t;

endpackage

// File: rtl/pwm_reg_if.sv
// Register-port bundle: SPI slave write/read port plus internal hardware-update port.
interface pwm_reg_if;
    import pwm_reg_pkg::*;

    logic [ADDR_W-1:0] spi_addr;
    logic [DATA_W-1:0] spi_data;
    logic              spi_wr_en;
    logic [DATA_W-1:0] spi_rd_data;
    logic              hw_req;
    logic [ADDR_W-1:0] hw_addr;
    logic [DATA_W-1:0] hw_data;
    logic              hw_gnt;

    modport master (
        output spi_addr, spi_data, spi_wr_en, hw_req, hw_addr, hw_data,
        input  spi_rd_data, hw_gnt
    );

    modport slave (
        input  spi_addr, spi_data, spi_wr_en, hw_req, hw_addr, hw_data,
        output spi_rd_data, hw_gnt
    );

endinterface

// File: rtl/pwm_shadow_bank.sv
// PWM configuration storage: single write port, shadow-to-active copy strobe, read mux.
// Build option: PWM_SHADOW_EN adds the shadow layer; without it writes go straight to active.
module pwm_shadow_bank
    import pwm_reg_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  reg_wr_t                wr,
    input  logic                   copy,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [DATA_W-1:0]      rd_data,
    output logic [DATA_W*NREG-1:0] active_regs
);

    logic [DATA_W-1:0] active_q [NREG];

`ifdef PWM_SHADOW_EN
    logic [DATA_W-1:0] shadow_q [NREG];

    // Shadow takes bus writes; unmapped addresses match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) shadow_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (wr_en && (wr.addr == ADDR_W'(i))) shadow_q[i] <= wr.data;
            end
        end
    end

    // Active takes the pre-write shadow image on the copy strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) active_q[i] <= '0;
        end else if (copy) begin
            for (int i = 0; i < int'(NREG); i++) active_q[i] <= shadow_q[i];
        end
    end

    // Reads return the shadow (programmed) value.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (rd_addr == ADDR_W'(i)) rd_data = shadow_q[i];
        end
    end
`else
    logic unused_copy;
    assign unused_copy = copy;

    // Without shadowing, bus writes land directly in the active registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) active_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (wr_en && (wr.addr == ADDR_W'(i))) active_q[i] <= wr.data;
            end
        end
    end

    // Reads return the active value.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (rd_addr == ADDR_W'(i)) rd_data = active_q[i];
        end
    end
`endif

    // Flatten active registers for the PWM datapath.
    always_comb begin
        active_regs = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            active_regs[DATA_W*i +: DATA_W] = active_q[i];
        end
    end

endmodule

// File: rtl/pwm_reg_ctrl.sv
// Register-bank controller: SPI edge detect, SPI-priority write arbiter, period-aligned update FSM.
// Build option: PWM_SHADOW_EN enables shadow registers and the CTRL-armed update sequencer.
module pwm_reg_ctrl
    import pwm_reg_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pwm_reg_if.slave               bus,
    input  logic                   period_end,
    output logic [DATA_W*NREG-1:0] active_regs,
    output logic                   busy
);

    logic              spi_wr_q;
    logic              spi_evt;
    logic              wr_en;
    reg_wr_t           wr;
    logic              copy;
    logic              pending;
    logic [DATA_W-1:0] bank_rd;

    // Previous write-enable level; resets high so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) spi_wr_q <= 1'b1;
        else        spi_wr_q <= bus.spi_wr_en;
    end

    // One bank write per cycle; an SPI event wins and the hw port waits.
    always_comb begin
        spi_evt    = bus.spi_wr_en && !spi_wr_q;
        bus.hw_gnt = bus.hw_req && !spi_evt;
        wr_en      = spi_evt || bus.hw_req;
        wr         = '{addr: bus.hw_addr, data: bus.hw_data};
        if (spi_evt) wr = '{addr: bus.spi_addr, data: bus.spi_data};
    end

`ifdef PWM_SHADOW_EN
    upd_state_t state_q;
    upd_state_t state_d;
    logic       ctrl_arm;

    assign ctrl_arm = spi_evt && (bus.spi_addr == CTRL_ADDR) && bus.spi_data[CTRL_UPD_BIT];

    // Update FSM state register; busy is registered alongside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= UPD_IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == UPD_COPY);
        end
    end

    // Arm from CTRL, wait for period wrap, copy for exactly one cycle.
    always_comb begin
        state_d = state_q;
        copy    = 1'b0;
        pending = 1'b1;
        case (state_q)
            UPD_IDLE: begin
                pending = 1'b0;
                if (ctrl_arm) state_d = UPD_ARMED;
            end
            UPD_ARMED: begin
                if (period_end) state_d = UPD_COPY;
            end
            UPD_COPY: begin
                copy    = 1'b1;
                state_d = UPD_IDLE;
            end
            default: begin
                pending = 1'b0;
                state_d = UPD_IDLE;
            end
        endcase
    end
`else
    logic unused_period_end;
    assign unused_period_end = period_end;
    assign copy              = 1'b0;
    assign pending           = 1'b0;
    assign busy              = 1'b0;
`endif

    pwm_shadow_bank #(.NREG(NREG)) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr          (wr),
        .copy        (copy),
        .rd_addr     (bus.spi_addr),
        .rd_data     (bank_rd),
        .active_regs (active_regs)
    );

    // CTRL reads back the pending flag; everything else comes from the bank.
    always_comb begin
        bus.spi_rd_data = bank_rd;
        if (bus.spi_addr == CTRL_ADDR) bus.spi_rd_data = {{(DATA_W-1){1'b0}}, pending};
    end

endmodule

// File: tb/tb_pwm_reg_ctrl.sv
// Self-checking bench for pwm_reg_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_pwm_reg_ctrl;

    localparam int NREG = 8;
`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              period_end = 1'b0;
    logic [8*NREG-1:0] active_regs;
    logic              busy;

    pwm_reg_if bus();

    pwm_reg_ctrl #(.NREG(NREG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .period_end  (period_end),
        .active_regs (active_regs),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: register images, write-enable history, update status.
    logic [7:0] m_shadow [16];
    logic [7:0] m_active [16];
    bit         m_prev_en = 1'b1;
    bit         m_armed = 1'b0;
    bit         m_copy = 1'b0;

    function automatic bit spi_event();
        return bus.spi_wr_en && !m_prev_en;
    endfunction

    function automatic logic exp_gnt();
        return bus.hw_req && !spi_event();
    endfunction

    function automatic logic [7:0] exp_rd(input logic [3:0] a);
        if (int'(a) < NREG) return SHADOW ? m_shadow[a] : m_active[a];
        if (a == 4'hF) return (SHADOW && (m_armed || m_copy)) ? 8'h01 : 8'h00;
        return 8'h00;
    endfunction

    function automatic logic [8*NREG-1:0] exp_act();
        logic [8*NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[8*i +: 8] = m_active[i];
        return v;
    endfunction

    task automatic model_update();
        bit         wr;
        logic [3:0] a;
        logic [7:0] d;
        bit         ev;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin m_shadow[i] = 8'h00; m_active[i] = 8'h00; end
            m_prev_en = 1'b1; m_armed = 1'b0; m_copy = 1'b0;
            return;
        end
        ev = spi_event();
        wr = 1'b0; a = 4'h0; d = 8'h00;
        if (ev) begin wr = 1'b1; a = bus.spi_addr; d = bus.spi_data; end
        else if (bus.hw_req) begin wr = 1'b1; a = bus.hw_addr; d = bus.hw_data; end
        if (m_copy) begin
            for (int i = 0; i < NREG; i++) m_active[i] = m_shadow[i];
            m_copy = 1'b0;
        end else if (m_armed) begin
            if (period_end) begin m_armed = 1'b0; m_copy = 1'b1; end
        end else if (SHADOW && ev && bus.spi_addr == 4'hF && bus.spi_data[0]) begin
            m_armed = 1'b1;
        end
        if (wr && int'(a) < NREG) begin
            if (SHADOW) m_shadow[a] = d;
            else        m_active[a] = d;
        end
        m_prev_en = bus.spi_wr_en;
    endtask

    // Advance one clock; inputs are driven at the negedge, model follows the posedge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.spi_wr_en = 1'b0; bus.spi_addr = 4'h0; bus.spi_data = 8'h00;
        bus.hw_req = 1'b1; bus.hw_addr = 4'h1; bus.hw_data = 8'hAB; period_end = 1'b1;
        step(); step(); #1;
        vectors++; if (bus.hw_gnt !== 1'b1) begin miscompares++; $display("FAIL reset_gnt: got %b expected 1", bus.hw_gnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (active_regs !== '0) begin miscompares++; $display("FAIL reset_active: got %h expected 0", active_regs); end
        for (int a = 0; a < 16; a++) begin
            bus.spi_addr = 4'(a); #1;
            vectors++; if (bus.spi_rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd[%0d]: got %h expected 00", a, bus.spi_rd_data); end
        end
        rst_n = 1'b1; bus.hw_req = 1'b0; period_end = 1'b0;
        step();
    endtask

    task automatic test_spi_hold();
        bus.spi_addr = 4'h2; bus.spi_data = 8'h5A; bus.spi_wr_en = 1'b1;
        step();
        bus.spi_data = 8'hA5;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++; if (bus.spi_rd_data !== 8'h5A) begin miscompares++; $display("FAIL hold_rd c%0d: got %h expected 5a", c, bus.spi_rd_data); end
            vectors++; if (active_regs[23:16] !== (SHADOW ? 8'h00 : 8'h5A)) begin miscompares++; $display("FAIL hold_active2 c%0d: got %h expected %h", c, active_regs[23:16], SHADOW ? 8'h00 : 8'h5A); end
            step();
        end
        bus.spi_wr_en = 1'b0;
        step();
    endtask

    task automatic test_collision();
        bus.spi_wr_en = 1'b1; bus.spi_addr = 4'h4; bus.spi_data = 8'h33;
        bus.hw_req = 1'b1; bus.hw_addr = 4'h3; bus.hw_data = 8'h11; #1;
        vectors++; if (bus.hw_gnt !== 1'b0) begin miscompares++; $display("FAIL coll_gnt0: got %b expected 0", bus.hw_gnt); end
        step(); #1;
        vectors++; if (bus.hw_gnt !== 1'b1) begin miscompares++; $display("FAIL coll_gnt1: got %b expected 1", bus.hw_gnt); end
        step();
        bus.hw_req = 1'b0; bus.spi_wr_en = 1'b0; bus.spi_addr = 4'h3; #1;
        vectors++; if (bus.spi_rd_data !== 8'h11) begin miscompares++; $display("FAIL coll_rd3: got %h expected 11", bus.spi_rd_data); end
        bus.spi_addr = 4'h4; #1;
        vectors++; if (bus.spi_rd_data !== 8'h33) begin miscompares++; $display("FAIL coll_rd4: got %h expected 33", bus.spi_rd_data); end
        step();
    endtask

    task automatic test_commit();
        bus.spi_wr_en = 1'b1; bus.spi_addr = 4'hF; bus.spi_data = 8'h01;
        step();
        bus.spi_wr_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++; if (bus.spi_rd_data !== 8'(SHADOW)) begin miscompares++; $display("FAIL commit_armed c%0d: got %h expected %h", c, bus.spi_rd_data, 8'(SHADOW)); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL commit_busy_pre c%0d: got %b expected 0", c, busy); end
            step();
        end
        period_end = 1'b1;
        step();
        period_end = 1'b0; #1;
        vectors++; if (busy !== SHADOW) begin miscompares++; $display("FAIL commit_busy_copy: got %b expected %b", busy, SHADOW); end
        vectors++; if (bus.spi_rd_data !== 8'(SHADOW)) begin miscompares++; $display("FAIL commit_ctrl_copy: got %h expected %h", bus.spi_rd_data, 8'(SHADOW)); end
        vectors++; if (active_regs[23:16] !== (SHADOW ? 8'h00 : 8'h5A)) begin miscompares++; $display("FAIL commit_active_copy: got %h expected %h", active_regs[23:16], SHADOW ? 8'h00 : 8'h5A); end
        step(); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL commit_busy_post: got %b expected 0", busy); end
        vectors++; if (active_regs[23:16] !== 8'h5A) begin miscompares++; $display("FAIL commit_active_post: got %h expected 5a", active_regs[23:16]); end
        vectors++; if (bus.spi_rd_data !== 8'h00) begin miscompares++; $display("FAIL commit_ctrl_post: got %h expected 00", bus.spi_rd_data); end
        step();
    endtask

    task automatic test_copy_write();
        bus.spi_wr_en = 1'b1; bus.spi_addr = 4'hF; bus.spi_data = 8'h01; period_end = 1'b1;
        step();
        bus.spi_wr_en = 1'b0; period_end = 1'b0; #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cw_busy_arm: got %b expected 0", busy); end
        vectors++; if (bus.spi_rd_data !== 8'(SHADOW)) begin miscompares++; $display("FAIL cw_armed: got %h expected %h", bus.spi_rd_data, 8'(SHADOW)); end
        step();
        period_end = 1'b1;
        step();
        period_end = 1'b0; bus.spi_wr_en = 1'b1; bus.spi_addr = 4'h2; bus.spi_data = 8'h77; #1;
        vectors++; if (busy !== SHADOW) begin miscompares++; $display("FAIL cw_busy_copy: got %b expected %b", busy, SHADOW); end
        step();
        bus.spi_wr_en = 1'b0; #1;
        vectors++; if (active_regs[23:16] !== (SHADOW ? 8'h5A : 8'h77)) begin miscompares++; $display("FAIL cw_active2: got %h expected %h", active_regs[23:16], SHADOW ? 8'h5A : 8'h77); end
        vectors++; if (bus.spi_rd_data !== 8'h77) begin miscompares++; $display("FAIL cw_rd2: got %h expected 77", bus.spi_rd_data); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.spi_wr_en = 1'b1; bus.spi_addr = 4'hF; bus.spi_data = 8'h01;
        step();
        rst_n = 1'b0; period_end = 1'b1;
        step();
        rst_n = 1'b1; period_end = 1'b0; bus.spi_addr = 4'h1; bus.spi_data = 8'h99;
        step();
        period_end = 1'b1;
        step();
        period_end = 1'b0; #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        vectors++; if (active_regs !== '0) begin miscompares++; $display("FAIL rmid_active: got %h expected 0", active_regs); end
        for (int a = 0; a < 16; a++) begin
            bus.spi_addr = 4'(a); #1;
            vectors++; if (bus.spi_rd_data !== 8'h00) begin miscompares++; $display("FAIL rmid_rd[%0d]: got %h expected 00", a, bus.spi_rd_data); end
        end
        bus.spi_wr_en = 1'b0;
        step();
    endtask

    task automatic test_unmapped();
        bus.hw_req = 1'b1; bus.hw_addr = 4'h5; bus.hw_data = 8'h42;
        step();
        bus.hw_req = 1'b0; bus.spi_wr_en = 1'b1; bus.spi_addr = 4'hC; bus.spi_data = 8'hFF;
        step();
        bus.spi_wr_en = 1'b0; bus.hw_req = 1'b1; bus.hw_addr = 4'hC; bus.hw_data = 8'hEE; #1;
        vectors++; if (bus.hw_gnt !== 1'b1) begin miscompares++; $display("FAIL unm_gnt_c: got %b expected 1", bus.hw_gnt); end
        step();
        bus.hw_addr = 4'hF; bus.hw_data = 8'h01; #1;
        vectors++; if (bus.hw_gnt !== 1'b1) begin miscompares++; $display("FAIL unm_gnt_f: got %b expected 1", bus.hw_gnt); end
        step();
        bus.hw_req = 1'b0;
        bus.spi_addr = 4'h5; #1;
        vectors++; if (bus.spi_rd_data !== 8'h42) begin miscompares++; $display("FAIL unm_rd5: got %h expected 42", bus.spi_rd_data); end
        bus.spi_addr = 4'hC; #1;
        vectors++; if (bus.spi_rd_data !== 8'h00) begin miscompares++; $display("FAIL unm_rdc: got %h expected 00", bus.spi_rd_data); end
        bus.spi_addr = 4'hF; #1;
        vectors++; if (bus.spi_rd_data !== 8'h00) begin miscompares++; $display("FAIL unm_rdf: got %h expected 00", bus.spi_rd_data); end
        for (int a = 0; a < 16; a++) begin
            bus.spi_addr = 4'(a); #1;
            vectors++; if (bus.spi_rd_data !== exp_rd(4'(a))) begin miscompares++; $display("FAIL unm_rd[%0d]: got %h expected %h", a, bus.spi_rd_data, exp_rd(4'(a))); end
        end
        vectors++; if (active_regs !== exp_act()) begin miscompares++; $display("FAIL unm_active: got %h expected %h", active_regs, exp_act()); end
        step();
    endtask

    task automatic test_random(input int ncyc);
        int en_cnt = 0;
        bit hw_done = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (en_cnt == 0) begin
                bus.spi_wr_en = !bus.spi_wr_en;
                if (bus.spi_wr_en) begin
                    bus.spi_addr = 4'($urandom_range(0, 15));
                    bus.spi_data = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) begin bus.spi_addr = 4'hF; bus.spi_data = 8'h01; end
                end
                en_cnt = $urandom_range(1, 4);
            end
            en_cnt--;
            if (!bus.spi_wr_en) bus.spi_addr = 4'($urandom_range(0, 15));
            if (!bus.hw_req || hw_done) begin
                bus.hw_req  = ($urandom_range(0, 2) == 0);
                bus.hw_addr = 4'($urandom_range(0, 15));
                bus.hw_data = 8'($urandom);
            end
            period_end = ($urandom_range(0, 4) == 0);
            #1;
            vectors++; if (bus.hw_gnt !== exp_gnt()) begin miscompares++; $display("FAIL rnd_gnt c%0d: got %b expected %b", c, bus.hw_gnt, exp_gnt()); end
            vectors++; if (bus.spi_rd_data !== exp_rd(bus.spi_addr)) begin miscompares++; $display("FAIL rnd_rd c%0d a%0d: got %h expected %h", c, bus.spi_addr, bus.spi_rd_data, exp_rd(bus.spi_addr)); end
            vectors++; if (busy !== m_copy) begin miscompares++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, m_copy); end
            vectors++; if (active_regs !== exp_act()) begin miscompares++; $display("FAIL rnd_active c%0d: got %h expected %h", c, active_regs, exp_act()); end
            hw_done = bus.hw_req && exp_gnt();
            step();
        end
        bus.spi_wr_en = 1'b0; bus.hw_req = 1'b0; period_end = 1'b0;
        step();
    endtask

    initial begin
        bus.spi_wr_en = 1'b0; bus.spi_addr = 4'h0; bus.spi_data = 8'h00;
        bus.hw_req = 1'b0; bus.hw_addr = 4'h0; bus.hw_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_spi_hold();
        test_collision();
        test_commit();
        test_copy_write();
        test_reset_mid();
        test_unmapped();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
